reg_bank_8x16: RTL and testbench
================================

# reg_bank_8x16

Eight-entry, 16-bit general-purpose register bank sitting directly upstream of the CPU's 8:1 operand multiplexers. It holds architectural registers R0–R7 and presents all eight in parallel so each operand mux selects one with its 3-bit select. It accepts write-back through a valid/ready handshake and provides a multi-cycle sequenced clear with a busy indication and a per-register dirty mask.

## Interface
- WIDTH, 16, data width of each register and of the write-data port
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- WE  in  1  write request valid
- WA  in  3  write address, 3'b000 = R0 … 3'b111 = R7
- WD  in  WIDTH  write data
- WR_RDY  out  1  bank can accept a write this cycle
- CLR  in  1  start-clear request, single-cycle pulse or level
- BUSY  out  1  clear sequence in progress
- DIRTY  out  8  bit n set when Rn has been written since its last clear or reset
- R0 … R7  out  WIDTH each  current register contents, feed operand mux inputs A0 … A7

## Operation
- One clock domain and one reset; reset is synchronous and active-high, with priority over every other input.
- Reset values: R0–R7 = 0, DIRTY = 8'h00, BUSY = 0, state = IDLE, clear counter = 0; WR_RDY = 1 in the first cycle after rst deasserts.
- States:
  - IDLE: WR_RDY = 1, BUSY = 0.
  - CLEARING: WR_RDY = 0, BUSY = 1.
- Write acceptance: a write is accepted when WE && WR_RDY at a rising edge. R[WA] <= WD and DIRTY[WA] <= 1. WE while WR_RDY = 0 is not accepted and is not queued; the source holds WE/WA/WD until accepted.
- IDLE -> CLEARING when CLR = 1 at an edge. The 3-bit counter loads 0.
- In CLEARING, each edge sets R[cnt] <= 0, DIRTY[cnt] <= 0, and cnt <= cnt + 1.
- CLEARING -> IDLE on the edge that clears R7 (cnt = 7). The counter wraps to 0 and is not used again until the next CLR.
- CLR while in CLEARING is ignored; the sequence is not restarted or extended.
- CLR and WE together in IDLE: the write is accepted on that edge (WR_RDY is already 1), then the clear sequence starts. The written register ends at 0 with its DIRTY bit = 0.
- rst during CLEARING aborts the sequence. All registers go to 0 on that edge, state = IDLE.
- Outputs R0–R7, DIRTY, BUSY and WR_RDY are driven only from registered state, with no combinational path from inputs. WR_RDY = (state == IDLE).

## Timing
- Write latency: a write accepted at edge t is visible on R[WA] and DIRTY[WA] after edge t; downstream muxes see the new value in cycle t+1.
- Clear: CLR sampled at edge t gives BUSY = 1, WR_RDY = 0 from cycle t+1. R0 clears at edge t+1, R1 at t+2, … R7 at t+8. BUSY = 0, WR_RDY = 1 from cycle t+9. BUSY is high for exactly 8 cycles.
- Back-to-back writes: one write per cycle sustained in IDLE. A write to the same address on consecutive edges means the last write wins.
- No read-during-write bypass. In the acceptance cycle, R[WA] still shows the old value.

## Structure
- Shared CPU package holds:
  - REG_COUNT = 8
  - REG_ADDR_W = 3
  - the state enumeration (IDLE, CLEARING)
  - the data width constant used as the WIDTH default, shared with the operand mux
- Sub-module reg_cell: one WIDTH-bit register with load and synchronous clear, plus its dirty bit. It is instantiated eight times. The handshake, clear FSM and counter live in the top level.

## Test plan
- Reset then write: rst for 2 cycles, then WE = 1, WA = 3, WD = 16'hBEEF -> R3 = 16'hBEEF and DIRTY = 8'h08 one cycle later; all other Rn = 0.
- Fill all: write 16'h1000 + n to Rn for n = 0..7 on consecutive cycles -> each value appears the cycle after its write, DIRTY = 8'hFF, WR_RDY stays 1 throughout.
- Clear sequence: from the full state, pulse CLR at edge t -> BUSY high for cycles t+1..t+8, Rn reads 0 from cycle t+2+n, DIRTY = 8'h00 and WR_RDY = 1 at t+9.
- Write blocked during clear: hold WE = 1, WA = 5, WD = 16'h5555 from t+2 -> no update until WR_RDY returns; R5 = 16'h5555 and DIRTY = 8'h20 in cycle t+10; a second CLR at t+4 has no effect.
- Simultaneous CLR and WE in IDLE with WA = 7, WD = 16'hFFFF -> R7 = 16'hFFFF in cycle t+1, then 0 at t+9; DIRTY[7] = 0 at the end.
- Reset mid-clear: assert rst at t+4 of a clear -> all Rn = 0, DIRTY = 0, BUSY = 0 in the following cycle, and WR_RDY = 1 once rst deasserts.

Source files
------------

// File: rtl/reg_bank_8x16_pkg.sv
// ---------------------------------------------------------------------------
// reg_bank_8x16_pkg
// Shared CPU constants and types for the general-purpose register bank and
// the operand multiplexers that consume it.
//   REG_COUNT  : number of architectural registers (R0..R7)
//   REG_ADDR_W : width of a register address / operand-mux select
//   DATA_W     : data path width, default WIDTH of the bank and the muxes
//   state_t    : clear-sequencer state (IDLE, CLEARING)
//   reg_onehot : decodes a register address into a one-hot enable vector
// ---------------------------------------------------------------------------
package reg_bank_8x16_pkg;

    localparam int REG_COUNT  = 8;
    localparam int REG_ADDR_W = 3;
    localparam int DATA_W     = 16;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } state_t;

    function automatic logic [REG_COUNT-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
        logic [REG_COUNT-1:0] vec;
        vec       = '0;
        vec[addr] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/reg_bank_8x16_reg_cell.sv
// ---------------------------------------------------------------------------
// reg_cell
// One WIDTH-bit architectural register with its dirty flag.
//   clk   in  system clock
//   rst   in  synchronous active-high reset, clears value and dirty flag
//   clear in  synchronous clear from the bank's clear sequencer
//   load  in  accepted write for this register; sets the dirty flag
//   d     in  write data
//   q     out current register value
//   dirty out set when written since the last clear or reset
// Clear wins over load; the bank never asserts both in one cycle, but the
// ordering keeps the cell safe if it ever did.
// ---------------------------------------------------------------------------
module reg_cell #(
    parameter int WIDTH = reg_bank_8x16_pkg::DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             dirty
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            q     <= '0;
            dirty <= 1'b0;
        end else if (load) begin
            q     <= d;
            dirty <= 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank_8x16.sv
// ---------------------------------------------------------------------------
// reg_bank_8x16
// Eight-entry general-purpose register bank feeding the CPU operand muxes.
//   clk       in  system clock
//   rst       in  synchronous active-high reset (highest priority)
//   WE/WA/WD  in  write-back request: valid, address, data
//   WR_RDY    out bank can accept a write this cycle
//   CLR       in  start a sequenced clear of R0..R7 (pulse or level)
//   BUSY      out clear sequence in progress
//   DIRTY     out per-register written-since-clear mask
//   R0..R7    out register contents, all presented in parallel
//   fsm_state out clear-sequencer state, for observation only
//
// Handshake: a write transfers on a rising edge where WE && WR_RDY. WR_RDY
// depends only on registered state, never on WE, so the source must hold
// WE/WA/WD stable until it sees the transfer; refused writes are dropped,
// not queued.
//
// Clear: CLR in IDLE enters CLEARING with the counter at 0; each CLEARING
// edge zeroes R[cnt] and advances cnt, and the edge that zeroes R7 returns
// to IDLE. A write accepted on the same edge as CLR lands first and is then
// wiped by the sequence. CLR during CLEARING is ignored.
// ---------------------------------------------------------------------------
module reg_bank_8x16
    import reg_bank_8x16_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  WE,
    input  logic [REG_ADDR_W-1:0] WA,
    input  logic [WIDTH-1:0]      WD,
    output logic                  WR_RDY,
    input  logic                  CLR,
    output logic                  BUSY,
    output logic [REG_COUNT-1:0]  DIRTY,
    output logic [WIDTH-1:0]      R0,
    output logic [WIDTH-1:0]      R1,
    output logic [WIDTH-1:0]      R2,
    output logic [WIDTH-1:0]      R3,
    output logic [WIDTH-1:0]      R4,
    output logic [WIDTH-1:0]      R5,
    output logic [WIDTH-1:0]      R6,
    output logic [WIDTH-1:0]      R7,
    output state_t                fsm_state
);

    state_t                state;
    state_t                state_next;
    logic [REG_ADDR_W-1:0] cnt;
    logic                  wr_fire;
    logic                  last_clear;
    logic [REG_COUNT-1:0]  load_vec;
    logic [REG_COUNT-1:0]  clear_vec;
    logic [WIDTH-1:0]      q [REG_COUNT];

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    assign last_clear = (cnt == REG_ADDR_W'(REG_COUNT - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (CLR) state_next = CLEARING;
            CLEARING: if (last_clear) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        WR_RDY = 1'b0;
        BUSY   = 1'b0;
        case (state)
            IDLE:     WR_RDY = 1'b1;
            CLEARING: BUSY   = 1'b1;
            default:  WR_RDY = 1'b0;
        endcase
    end

    assign fsm_state = state;

    // Clear counter: held at 0 in IDLE so it starts from R0 on entry, and
    // wraps naturally from 7 back to 0 on the final clearing edge.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // ---------------- register cells ----------------
    assign wr_fire   = WE && WR_RDY;
    assign load_vec  = wr_fire ? reg_onehot(WA) : '0;
    assign clear_vec = (state == CLEARING) ? reg_onehot(cnt) : '0;

    for (genvar n = 0; n < REG_COUNT; n++) begin : g_cell
        reg_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .clear (clear_vec[n]),
            .load  (load_vec[n]),
            .d     (WD),
            .q     (q[n]),
            .dirty (DIRTY[n])
        );
    end

    assign R0 = q[0];
    assign R1 = q[1];
    assign R2 = q[2];
    assign R3 = q[3];
    assign R4 = q[4];
    assign R5 = q[5];
    assign R6 = q[6];
    assign R7 = q[7];

endmodule

// File: tb/tb_reg_bank_8x16.sv
// Testbench for reg_bank_8x16: directed scenarios followed by random traffic,
// checked every cycle against a register-file model held in plain arrays.
module tb_reg_bank_8x16;
  import reg_bank_8x16_pkg::*;

  localparam int W    = 16;
  localparam int SW   = 8 * W + 8 + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          we  = 1'b0;
  logic [2:0]    wa  = '0;
  logic [W-1:0]  wd  = '0;
  logic          clr = 1'b0;
  logic          wr_rdy;
  logic          busy;
  logic [7:0]    dirty;
  logic [W-1:0]  r0, r1, r2, r3, r4, r5, r6, r7;
  state_t        fsm_state;

  reg_bank_8x16 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .WE        (we),
    .WA        (wa),
    .WD        (wd),
    .WR_RDY    (wr_rdy),
    .CLR       (clr),
    .BUSY      (busy),
    .DIRTY     (dirty),
    .R0        (r0),
    .R1        (r1),
    .R2        (r2),
    .R3        (r3),
    .R4        (r4),
    .R5        (r5),
    .R6        (r6),
    .R7        (r7),
    .fsm_state (fsm_state)
  );

  // ---------------- reference model ----------------
  // Registers as an array, plus how many registers the clear still has to
  // wipe (0 = not clearing). The next register to wipe is 8 - clear_left.
  logic [W-1:0] m_reg [8];
  logic [7:0]   m_dirty;
  int           clear_left;

  logic [SW-1:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [SW-1:0] pack(input logic [W-1:0] rv [8], input logic [7:0] dv,
                                         input logic bv, input logic yv);
    logic [SW-1:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s[i*W +: W] = rv[i];
    s[8*W +: 8] = dv;
    s[8*W + 8]  = bv;
    s[8*W + 9]  = yv;
    return s;
  endfunction

  // Applies the edge to the model using the inputs currently driven, waits
  // for the DUT edge, and queues the expected post-edge state.
  task automatic step();
    if (rst) begin
      for (int i = 0; i < 8; i++) m_reg[i] = '0;
      m_dirty    = '0;
      clear_left = 0;
    end else if (clear_left > 0) begin
      m_reg[8 - clear_left]   = '0;
      m_dirty[8 - clear_left] = 1'b0;
      clear_left--;
    end else begin
      if (we) begin
        m_reg[wa]   = wd;
        m_dirty[wa] = 1'b1;
      end
      if (clr) clear_left = 8;
    end
    @(posedge clk);
    exp_q.push_back(pack(m_reg, m_dirty, clear_left > 0, clear_left == 0));
    #1;
  endtask

  task automatic idle(input int n);
    we  = 1'b0;
    clr = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write(input logic [2:0] a, input logic [W-1:0] d);
    we = 1'b1;
    wa = a;
    wd = d;
    step();
    we = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [SW-1:0] e;
      logic [W-1:0]  act_r [8];
      e = exp_q.pop_front();
      act_r[0] = r0; act_r[1] = r1; act_r[2] = r2; act_r[3] = r3;
      act_r[4] = r4; act_r[5] = r5; act_r[6] = r6; act_r[7] = r7;
      for (int i = 0; i < 8; i++) check($sformatf("R%0d", i), act_r[i], e[i*W +: W]);
      check("DIRTY", W'(dirty), W'(e[8*W +: 8]));
      check("BUSY", W'(busy), W'(e[8*W + 8]));
      check("WR_RDY", W'(wr_rdy), W'(e[8*W + 9]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_dirty    = '0;
    clear_left = 0;

    // Reset for two cycles, then write R3.
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    write(3'd3, 16'hBEEF);
    idle(1);

    // Fill all registers on consecutive cycles.
    we = 1'b1;
    for (int n = 0; n < 8; n++) begin
      wa = 3'(n);
      wd = 16'h1000 + 16'(n);
      step();
    end
    we = 1'b0;
    idle(1);

    // Clear with a write held from t+2 and a redundant CLR at t+4.
    clr = 1'b1;
    step();                              // edge t
    clr = 1'b0;
    step();                              // edge t+1
    we = 1'b1; wa = 3'd5; wd = 16'h5555;
    step();                              // edge t+2
    step();                              // edge t+3
    clr = 1'b1;
    step();                              // edge t+4
    clr = 1'b0;
    for (int i = 0; i < 5; i++) step();  // edges t+5..t+9, write lands at t+9
    we = 1'b0;
    idle(2);

    // CLR together with a write to R7 in IDLE.
    we = 1'b1; wa = 3'd7; wd = 16'hFFFF; clr = 1'b1;
    step();
    idle(10);

    // Reset in the middle of a clear.
    write(3'd1, 16'h0123);
    write(3'd6, 16'h0456);
    clr = 1'b1;
    step();
    clr = 1'b0;
    idle(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(2);

    // Random traffic, including refused writes and occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      clr = ($urandom_range(0, 24) == 0);
      we  = ($urandom_range(0, 1) == 1);
      wa  = 3'($urandom_range(0, 7));
      wd  = W'($urandom);
      step();
    end
    rst = 1'b0;
    idle(12);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    check("queue_drained", W'(exp_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
